// File: rtl/bsg_gateway_rail_seq.sv
// Gateway board supply-rail sequencer: ramps ASIC rail enables up and down with a
// programmable inter-rail delay, latches over-current faults, and lets the CPU override outputs.
module bsg_gateway_rail_seq #(
    parameter int num_rails_p = 3,
    parameter int cnt_width_p = 16,
    parameter int num_misc_p  = 13
) (
    input  logic                   clk_i,
    input  logic                   async_reset_i,
    input  logic                   pwr_rstn_i,
    input  logic                   override_p_i,
    input  logic                   override_n_i,
    input  logic [num_rails_p-1:0] override_rail_en_i,
    input  logic [num_misc_p-1:0]  override_misc_i,
    input  logic                   up_req_i,
    input  logic [cnt_width_p-1:0] delay_i,
    input  logic [num_rails_p-1:0] fault_i,
    input  logic                   clear_fault_i,
    output logic [num_rails_p-1:0] rail_en_o,
    output logic [num_misc_p-1:0]  misc_o,
    output logic [2:0]             state_o,
    output logic                   all_up_o,
    output logic [num_rails_p-1:0] fault_latched_o
);

    localparam int idx_width_lp = (num_rails_p > 1) ? $clog2(num_rails_p) : 1;
    localparam logic [idx_width_lp-1:0] last_idx_lp = idx_width_lp'(num_rails_p - 1);
    localparam logic [num_rails_p-1:0]  rail_one_lp = num_rails_p'(1);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_UP    = 3'd1,
        S_ON    = 3'd2,
        S_DOWN  = 3'd3,
        S_FAULT = 3'd4
    } state_e;

    state_e                    state_reg, state_next;
    logic [num_rails_p-1:0]    rail_reg, rail_next;
    logic [cnt_width_p-1:0]    cnt_reg, cnt_next;
    logic [idx_width_lp-1:0]   idx_reg, idx_next;
    logic [num_rails_p-1:0]    latched_reg, latched_next;
    logic                      sync1_reg, sync2_reg;

    logic                      pwr_ok;
    logic                      up_eff;
    logic                      ovr;
    logic [num_rails_p-1:0]    fault_hit;
    logic [num_rails_p-1:0]    rail_dn;
    logic [num_rails_p-1:0]    rail_en_next;
    logic [num_misc_p-1:0]     misc_next;

    // The power button is asynchronous to clk_i; two flops before anything uses it.
    always_ff @(posedge clk_i or posedge async_reset_i) begin
        if (async_reset_i) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= pwr_rstn_i;
            sync2_reg <= sync1_reg;
        end
    end

    assign pwr_ok = sync2_reg;
    assign up_eff = up_req_i & pwr_ok;
    assign ovr    = override_p_i & ~override_n_i & pwr_ok;

    // Only faults on rails we are actually driving count.
    for (genvar gi = 0; gi < num_rails_p; gi++) begin : g_fault
        assign fault_hit[gi] = fault_i[gi] & rail_reg[gi];
    end

    // idx always names the highest enabled rail, so a down step clears rail[idx].
    assign rail_dn = rail_reg & ~(rail_one_lp << idx_reg);

    always_ff @(posedge clk_i or posedge async_reset_i) begin
        if (async_reset_i) begin
            state_reg   <= S_OFF;
            rail_reg    <= '0;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            latched_reg <= '0;
        end else begin
            state_reg   <= state_next;
            rail_reg    <= rail_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            latched_reg <= latched_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rail_next    = rail_reg;
        cnt_next     = cnt_reg;
        idx_next     = idx_reg;
        latched_next = latched_reg;

        case (state_reg)
            S_OFF: begin
                if (up_eff) begin
                    state_next = S_UP;
                    rail_next  = rail_one_lp;
                    idx_next   = '0;
                    cnt_next   = delay_i;
                end
            end

            S_UP, S_ON, S_DOWN: begin
                if (|fault_hit) begin
                    state_next   = S_FAULT;
                    rail_next    = '0;
                    cnt_next     = '0;
                    idx_next     = '0;
                    latched_next = latched_reg | fault_hit;
                end else if ((state_reg != S_DOWN) && up_eff) begin
                    if (state_reg == S_UP) begin
                        if (cnt_reg != '0) begin
                            cnt_next = cnt_reg - cnt_width_p'(1);
                        end else if (idx_reg == last_idx_lp) begin
                            state_next = S_ON;
                        end else begin
                            idx_next  = idx_reg + idx_width_lp'(1);
                            rail_next = rail_reg | (rail_one_lp << (idx_reg + idx_width_lp'(1)));
                            cnt_next  = delay_i;
                        end
                    end
                end else if ((state_reg == S_DOWN) && (cnt_reg != '0)) begin
                    cnt_next = cnt_reg - cnt_width_p'(1);
                end else begin
                    // Entering DOWN and each later DOWN step share the same clear-one-rail action.
                    rail_next = rail_dn;
                    if (idx_reg == '0) begin
                        state_next = S_OFF;
                        cnt_next   = '0;
                    end else begin
                        state_next = S_DOWN;
                        idx_next   = idx_reg - idx_width_lp'(1);
                        cnt_next   = delay_i;
                    end
                end
            end

            S_FAULT: begin
                if (clear_fault_i && !up_eff && (fault_i == '0)) begin
                    state_next   = S_OFF;
                    latched_next = '0;
                end
            end

            default: begin
                state_next = S_OFF;
                rail_next  = '0;
                cnt_next   = '0;
                idx_next   = '0;
            end
        endcase
    end

    assign rail_en_next = ovr ? override_rail_en_i : rail_next;
    assign misc_next    = ovr ? override_misc_i : {num_misc_p{1'b1}};

    // Outputs are registered copies of the next-state values so they line up with the FSM.
    always_ff @(posedge clk_i or posedge async_reset_i) begin
        if (async_reset_i) begin
            rail_en_o       <= '0;
            misc_o          <= {num_misc_p{1'b1}};
            state_o         <= S_OFF;
            all_up_o        <= 1'b0;
            fault_latched_o <= '0;
        end else begin
            rail_en_o       <= rail_en_next;
            misc_o          <= misc_next;
            state_o         <= state_next;
            all_up_o        <= (state_next == S_ON);
            fault_latched_o <= latched_next;
        end
    end

endmodule

// File: doc/bsg_gateway_rail_seq.md
BSG_GATEWAY_RAIL_SEQ -- requirements
Module: bsg_gateway_rail_seq

Interface
REQ-001 SHALL have parameter num_rails_p, default 3, number of sequenced ASIC supply-rail enables (>=1).
REQ-002 SHALL have parameter cnt_width_p, default 16, width of the inter-rail delay counter (>=1).
REQ-003 SHALL have parameter num_misc_p, default 13, number of board strap outputs (pot/current-monitor address, INDEP, NRST, LEDs).
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port async_reset_i, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port pwr_rstn_i, input, 1, board power button (active-low, asynchronous to clk_i).
REQ-007 SHALL have ports override_p_i and override_n_i, input, 1 each, CPU override qualifier pair.
REQ-008 SHALL have port override_rail_en_i, input, num_rails_p, CPU-driven rail enables.
REQ-009 SHALL have port override_misc_i, input, num_misc_p, CPU-driven strap values.
REQ-010 SHALL have port up_req_i, input, 1, level request: 1 = power up, 0 = power down.
REQ-011 SHALL have port delay_i, input, cnt_width_p, inter-rail delay in cycles.
REQ-012 SHALL have port fault_i, input, num_rails_p, per-rail fault level (current-monitor alert).
REQ-013 SHALL have port clear_fault_i, input, 1, fault acknowledge.
REQ-014 SHALL have port rail_en_o, output, num_rails_p, rail enables to the board.
REQ-015 SHALL have port misc_o, output, num_misc_p, strap outputs.
REQ-016 SHALL have port state_o, output, 3, FSM state encoded as OFF=0, UP=1, ON=2, DOWN=3, FAULT=4.
REQ-017 SHALL have port all_up_o, output, 1, high only in ON.
REQ-018 SHALL have port fault_latched_o, output, num_rails_p, sticky fault record.

Function
REQ-019 SHALL synchronise pwr_rstn_i through two flops into pwr_ok.
REQ-020 SHALL define up_eff = up_req_i & pwr_ok, and ovr = override_p_i & ~override_n_i & pwr_ok.
REQ-021 SHALL register all outputs, so any input change is visible no earlier than the next edge.
REQ-022 SHALL drive rail_en_o = override_rail_en_i and misc_o = override_misc_i when ovr is 1; otherwise rail_en_o = FSM rail vector and misc_o = all ones.
REQ-023 SHALL keep the FSM running regardless of ovr; ovr only muxes outputs.
REQ-024 SHALL, in OFF with up_eff=1, enter UP on the next edge, set FSM rail[0]=1, idx=0, and load cnt with delay_i.
REQ-025 SHALL, in UP, decrement cnt while it is nonzero; at cnt==0 with idx<num_rails_p-1, increment idx, set rail[idx], and reload cnt from delay_i.
REQ-026 SHALL, in UP at cnt==0 with idx==num_rails_p-1, enter ON, giving a uniform spacing of delay_i+1 cycles.
REQ-027 SHALL, in UP or ON with up_eff=0, enter DOWN on the next edge, clear the highest set rail, and load cnt.
REQ-028 SHALL, in DOWN, decrement cnt; at cnt==0, clear the next-lower set rail and reload cnt; clearing rail[0] enters OFF on the same edge.
REQ-029 SHALL ignore up_eff=1 during DOWN; the FSM completes to OFF and re-ramps from OFF.
REQ-030 SHALL treat delay_i=0 as one rail per cycle; delay_i is sampled only at load.
REQ-031 SHALL, in UP/ON/DOWN, when any fault_i[k] & rail[k] is set, enter FAULT on the next edge, clear all FSM rails, and OR the masked faults into fault_latched_o.
REQ-032 SHALL give fault priority over any up_eff change on the same edge.
REQ-033 SHALL ignore faults on rails that are not enabled and in OFF/FAULT.
REQ-034 SHALL leave FAULT for OFF only when clear_fault_i=1, up_eff=0 and fault_i==0; fault_latched_o clears on that edge.
REQ-035 SHALL set all_up_o=1 exactly while state==ON.

Reset
REQ-036 SHALL, on async_reset_i high, immediately set state OFF, FSM rails 0, rail_en_o 0, misc_o all ones, all_up_o 0, fault_latched_o 0, cnt 0, idx 0, synchroniser 0.
REQ-037 SHALL, on reset assertion mid-ramp, force all rails off with no ordered power-down.

Verification
REQ-038 SHALL cover power-up: rails=3, delay_i=4, pwr_rstn=1, up_req rises before edge E -> rail_en 001@E, 011@E+5, 111@E+10, state ON/all_up@E+15.
REQ-039 SHALL cover power-down: up_req falls from ON, sampled at edge F -> rail_en 011@F, 001@F+5, 000 and OFF@F+10.
REQ-040 SHALL cover fault: in ON, fault_i=010 for 1 cycle -> next edge rail_en 000, FAULT, fault_latched 010; clear_fault with up_req=0 -> OFF, latched 000.
REQ-041 SHALL cover override: override_p=1, override_n=0, override_rail_en=101, override_misc=0 -> next edge rail_en 101, misc 0; pwr_rstn low -> after 2 sync cycles plus 1, outputs revert and FSM ramps down.
REQ-042 SHALL cover abort: up_req drops while UP at idx=1 -> DOWN clears rail1 then rail0, delay_i+1 apart; up_req re-raised mid-DOWN -> reaches OFF, then re-ramps.
REQ-043 SHALL cover reset mid-UP: async_reset_i pulsed between edges -> rail_en 000 and state 0 before the next edge.
